// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for lock with bounded retries,
// qualifies lock as stable, then releases the core reset; re-runs on lock loss or restart.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 74250,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned CNT_W         = 17,
    parameter int unsigned RETRY_W       = 3
) (
    input  logic               clk_74a,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               core_reset_n,
    output logic               pll_ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [7:0]         relock_events,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_WAIT  = 3'd1,
        S_STAB  = 3'd2,
        S_RUN   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_d;
    logic [7:0]         relock_d;
    logic               sync_meta, locked_s;

    // NOTE: every sequential block uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_count;
        relock_d = relock_events;
        unique case (state_q)
            S_RST: begin
                if (restart) begin
                    cnt_d = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (restart) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end else if (locked_s) begin
                    // Lock wins over a coincident timeout.
                    state_d = S_STAB;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_count == RETRY_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RST;
                        retry_d = retry_count + RETRY_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STAB: begin
                if (restart) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Lock loss takes precedence over restart and is counted.
                if (!locked_s) begin
                    state_d  = S_RST;
                    cnt_d    = '0;
                    relock_d = (relock_events == 8'hFF) ? relock_events : relock_events + 8'd1;
                end else if (restart) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                end
            end
            S_FAULT: begin
                if (restart) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state_q       <= S_RST;
            cnt_q         <= '0;
            retry_count   <= '0;
            relock_events <= '0;
            pll_rst       <= 1'b1;
            core_reset_n  <= 1'b0;
            pll_ready     <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_count   <= retry_d;
            relock_events <= relock_d;
            pll_rst       <= (state_d == S_RST) || (state_d == S_FAULT);
            core_reset_n  <= (state_d == S_RUN);
            pll_ready     <= (state_d == S_RUN);
            fault         <= (state_d == S_FAULT);
        end
    end

    assign state = state_q;

endmodule
